// File: rtl/rgb2y_front_end_if.sv
// Video bus between the RGB source and the luma front end.
// master drives RGB/sync and reads luma, tags and line length; slave is the front end.
interface rgb2y_front_end_if #(
   parameter int unsigned X_W = 11,
   parameter int unsigned Y_W = 10
);
   logic [7:0]     r_i;
   logic [7:0]     g_i;
   logic [7:0]     b_i;
   logic           dv_i;
   logic           hs_i;
   logic           vs_i;
   logic [7:0]     y_o;
   logic           dv_o;
   logic           hs_o;
   logic           vs_o;
   logic           hs_edge_o;
   logic [X_W-1:0] x_index;
   logic [Y_W-1:0] y_index;
   logic [X_W-1:0] line_len;

   modport master (
      output r_i, g_i, b_i, dv_i, hs_i, vs_i,
      input  y_o, dv_o, hs_o, vs_o, hs_edge_o, x_index, y_index, line_len
   );

   modport slave (
      input  r_i, g_i, b_i, dv_i, hs_i, vs_i,
      output y_o, dv_o, hs_o, vs_o, hs_edge_o, x_index, y_index, line_len
   );
endinterface

// File: rtl/rgb2y_front_end.sv
// RGB to luma front end: 3-stage luma pipeline with matched sync delay,
// per-pixel column/row tags, hsync edge flag and active line length.
module rgb2y_front_end #(
   parameter int unsigned COEF_R = 77,
   parameter int unsigned COEF_G = 150,
   parameter int unsigned COEF_B = 29,
   parameter int unsigned X_W    = 11,
   parameter int unsigned Y_W    = 10
) (
   input logic               clk,
   input logic               rst,
   rgb2y_front_end_if.slave  bus
);
   localparam int unsigned    PIPE  = 3;
   localparam logic [7:0]     C_R   = 8'(COEF_R);
   localparam logic [7:0]     C_G   = 8'(COEF_G);
   localparam logic [7:0]     C_B   = 8'(COEF_B);
   localparam logic [X_W-1:0] X_MAX = '1;
   localparam logic [Y_W-1:0] Y_MAX = '1;

   logic           r_hs_q, r_vs_q, r_line_has_px;
   logic [X_W-1:0] r_xcnt, r_line_len;
   logic [Y_W-1:0] r_ycnt;

   logic           w_hs_rise, w_vs_rise, w_edge, w_len_upd, w_line_has_px_nxt;
   logic [X_W-1:0] w_xtag, w_xcnt_nxt;
   logic [Y_W-1:0] w_ycnt_nxt;

   logic [15:0]    r_pr, r_pg, r_pb;
   logic [17:0]    r_sum;
   logic [7:0]     r_y;

   logic [PIPE-1:0] r_dv_sr, r_hs_sr, r_vs_sr, r_he_sr;
   logic [X_W-1:0]  r_x_sr [PIPE];
   logic [Y_W-1:0]  r_y_sr [PIPE];

   // Input-side line/frame bookkeeping; an edge pixel belongs to the new line
   always_comb begin
      w_hs_rise         = bus.hs_i & ~r_hs_q;
      w_vs_rise         = bus.vs_i & ~r_vs_q;
      w_edge            = w_hs_rise | w_vs_rise;
      w_len_upd         = w_hs_rise & r_line_has_px;
      w_xtag            = w_edge ? '0 : r_xcnt;
      w_xcnt_nxt        = r_xcnt;
      w_ycnt_nxt        = r_ycnt;
      w_line_has_px_nxt = r_line_has_px | bus.dv_i;
      if (w_edge) begin
         w_xcnt_nxt        = bus.dv_i ? X_W'(1) : '0;
         w_line_has_px_nxt = bus.dv_i;
      end else if (bus.dv_i && (r_xcnt != X_MAX)) begin
         w_xcnt_nxt = r_xcnt + X_W'(1);
      end
      if (w_vs_rise) begin
         w_ycnt_nxt = '0;
      end else if (w_len_upd && (r_ycnt != Y_MAX)) begin
         w_ycnt_nxt = r_ycnt + Y_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hs_q        <= 1'b0;
         r_vs_q        <= 1'b0;
         r_line_has_px <= 1'b0;
         r_xcnt        <= '0;
         r_ycnt        <= '0;
         r_line_len    <= '0;
      end else begin
         r_hs_q        <= bus.hs_i;
         r_vs_q        <= bus.vs_i;
         r_line_has_px <= w_line_has_px_nxt;
         r_xcnt        <= w_xcnt_nxt;
         r_ycnt        <= w_ycnt_nxt;
         if (w_len_upd) r_line_len <= r_xcnt;
      end
   end

   // Luma datapath runs every cycle; sidebands follow in lockstep
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pr    <= '0;
         r_pg    <= '0;
         r_pb    <= '0;
         r_sum   <= '0;
         r_y     <= '0;
         r_dv_sr <= '0;
         r_hs_sr <= '0;
         r_vs_sr <= '0;
         r_he_sr <= '0;
         for (int i = 0; i < PIPE; i++) begin
            r_x_sr[i] <= '0;
            r_y_sr[i] <= '0;
         end
      end else begin
         r_pr    <= 16'(bus.r_i) * 16'(C_R);
         r_pg    <= 16'(bus.g_i) * 16'(C_G);
         r_pb    <= 16'(bus.b_i) * 16'(C_B);
         r_sum   <= 18'(r_pr) + 18'(r_pg) + 18'(r_pb) + 18'd128;
         r_y     <= (|r_sum[17:16]) ? 8'hFF : r_sum[15:8];
         r_dv_sr <= {r_dv_sr[PIPE-2:0], bus.dv_i};
         r_hs_sr <= {r_hs_sr[PIPE-2:0], bus.hs_i};
         r_vs_sr <= {r_vs_sr[PIPE-2:0], bus.vs_i};
         r_he_sr <= {r_he_sr[PIPE-2:0], w_hs_rise};
         r_x_sr[0] <= w_xtag;
         r_y_sr[0] <= w_ycnt_nxt;
         for (int i = 1; i < PIPE; i++) begin
            r_x_sr[i] <= r_x_sr[i-1];
            r_y_sr[i] <= r_y_sr[i-1];
         end
      end
   end

   assign bus.y_o       = r_y;
   assign bus.dv_o      = r_dv_sr[PIPE-1];
   assign bus.hs_o      = r_hs_sr[PIPE-1];
   assign bus.vs_o      = r_vs_sr[PIPE-1];
   assign bus.hs_edge_o = r_he_sr[PIPE-1];
   assign bus.x_index   = r_x_sr[PIPE-1];
   assign bus.y_index   = r_y_sr[PIPE-1];
   assign bus.line_len  = r_line_len;
endmodule

// File: tb/tb_rgb2y_front_end.sv
// Bench for rgb2y_front_end: constant colour table, directed line/frame/reset
// sequences and random video, all checked against a queue-based reference model.
module tb_rgb2y_front_end;
   localparam int unsigned X_W = 11;
   localparam int unsigned Y_W = 10;
   localparam int X_SAT = (1 << X_W) - 1;
   localparam int Y_SAT = (1 << Y_W) - 1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   rgb2y_front_end_if #(.X_W(X_W), .Y_W(Y_W)) bus ();

   rgb2y_front_end #(
      .COEF_R(77), .COEF_G(150), .COEF_B(29), .X_W(X_W), .Y_W(Y_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      int y;
      int dv;
      int hs;
      int vs;
      int he;
      int x;
      int yi;
   } exp_t;

   typedef struct {
      int r;
      int g;
      int b;
      int y;
   } vec_t;

   int   n_vec = 0;
   int   n_err = 0;
   int   cyc   = 0;
   exp_t q[$];
   int   m_phs, m_pvs, m_col, m_row, m_has, m_len;

   function automatic int luma(int r, int g, int b);
      int s;
      s = (r * 77 + g * 150 + b * 29 + 128) / 256;
      return (s > 255) ? 255 : s;
   endfunction

   task automatic model_reset();
      exp_t z;
      z = '{0, 0, 0, 0, 0, 0, 0};
      m_phs = 0; m_pvs = 0; m_col = 0; m_row = 0; m_has = 0; m_len = 0;
      q.delete();
      q.push_back(z);
      q.push_back(z);
   endtask

   // Reference behaviour for one sampled input cycle, expressed on plain integers
   task automatic model_step();
      int   dv, hs, vs, hr, vr, ed;
      exp_t e;
      dv = int'(bus.dv_i); hs = int'(bus.hs_i); vs = int'(bus.vs_i);
      hr = (hs == 1 && m_phs == 0) ? 1 : 0;
      vr = (vs == 1 && m_pvs == 0) ? 1 : 0;
      ed = hr | vr;
      e.x = ed ? 0 : m_col;
      if (vr == 1) m_row = 0;
      else if (hr == 1 && m_has == 1) m_row = (m_row < Y_SAT) ? m_row + 1 : Y_SAT;
      if (hr == 1 && m_has == 1) m_len = m_col;
      if (ed == 1) m_col = dv;
      else if (dv == 1) m_col = (m_col < X_SAT) ? m_col + 1 : X_SAT;
      m_has = (ed == 1) ? dv : (m_has | dv);
      m_phs = hs; m_pvs = vs;
      e.y = luma(int'(bus.r_i), int'(bus.g_i), int'(bus.b_i));
      e.dv = dv; e.hs = hs; e.vs = vs; e.he = hr; e.yi = m_row;
      q.push_back(e);
   endtask

   task automatic check_out();
      exp_t e;
      bit   ok;
      e = q.pop_front();
      ok = (int'(bus.y_o) == e.y) && (int'(bus.dv_o) == e.dv) && (int'(bus.hs_o) == e.hs) &&
           (int'(bus.vs_o) == e.vs) && (int'(bus.hs_edge_o) == e.he) &&
           (int'(bus.line_len) == m_len) &&
           (e.dv == 0 || (int'(bus.x_index) == e.x && int'(bus.y_index) == e.yi));
      n_vec++;
      if (!ok) begin
         n_err++;
         $display("FAIL model cyc=%0d act y=%0d dv=%0d hs=%0d vs=%0d he=%0d x=%0d yi=%0d len=%0d exp y=%0d dv=%0d hs=%0d vs=%0d he=%0d x=%0d yi=%0d len=%0d",
                  cyc, bus.y_o, bus.dv_o, bus.hs_o, bus.vs_o, bus.hs_edge_o, bus.x_index,
                  bus.y_index, bus.line_len, e.y, e.dv, e.hs, e.vs, e.he, e.x, e.yi, m_len);
      end
   endtask

   task automatic chk(string name, int act, int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d act=%0d exp=%0d", name, cyc, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      cyc++;
      check_out();
   endtask

   task automatic drive(int r, int g, int b, int dv, int hs, int vs);
      bus.r_i = 8'(r); bus.g_i = 8'(g); bus.b_i = 8'(b);
      bus.dv_i = dv[0]; bus.hs_i = hs[0]; bus.vs_i = vs[0];
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[8];
      int   outs;
      tbl[0] = '{255, 255, 255, 255};
      tbl[1] = '{0,   0,   0,   0};
      tbl[2] = '{255, 0,   0,   77};
      tbl[3] = '{0,   255, 0,   149};
      tbl[4] = '{0,   0,   255, 29};
      tbl[5] = '{128, 128, 128, 128};
      tbl[6] = '{10,  20,  30,  18};
      tbl[7] = '{200, 100, 50,  124};

      rst = 1'b1;
      idle();
      repeat (3) @(posedge clk);
      #1;
      outs = int'(bus.y_o) + int'(bus.dv_o) + int'(bus.hs_o) + int'(bus.vs_o) +
             int'(bus.hs_edge_o) + int'(bus.x_index) + int'(bus.y_index) + int'(bus.line_len);
      chk("reset_outputs", outs, 0);
      @(negedge clk);
      model_reset();
      rst = 1'b0;

      // Constant colour table, each pixel observed three cycles later
      foreach (tbl[i]) begin
         drive(tbl[i].r, tbl[i].g, tbl[i].b, 1, 0, 0);
         tick();
         idle();
         tick();
         tick();
         chk("table_y", int'(bus.y_o), tbl[i].y);
         chk("table_dv", int'(bus.dv_o), 1);
      end

      // 640-pixel line between hsync pulses
      drive(0, 0, 0, 0, 0, 1); tick();
      idle(); tick();
      drive(0, 0, 0, 0, 1, 0); tick();
      idle(); tick();
      for (int i = 0; i < 640; i++) begin
         drive($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), 1, 0, 0);
         tick();
      end
      idle(); repeat (3) tick();
      drive(0, 0, 0, 0, 1, 0); tick();
      chk("line_len_640", int'(bus.line_len), 640);
      idle(); tick();

      // vsync, then three lines separated by empty hsync lines
      drive(0, 0, 0, 0, 0, 1); tick();
      idle(); tick();
      for (int k = 0; k < 3; k++) begin
         drive(0, 0, 0, 0, 1, 0); tick();
         drive(50, 60, 70, 1, 0, 0); tick();
         idle(); tick(); tick();
         chk("row_dv", int'(bus.dv_o), 1);
         chk("row_index", int'(bus.y_index), k);
         drive(0, 0, 0, 0, 1, 0); tick();
         idle(); tick(); tick();
      end

      // hsync rise coincident with a pixel
      drive(1, 2, 3, 1, 1, 0); tick();
      drive(4, 5, 6, 1, 1, 0); tick();
      idle(); tick();
      chk("edge_px_x", int'(bus.x_index), 0);
      chk("edge_px_he", int'(bus.hs_edge_o), 1);
      chk("edge_px_hs", int'(bus.hs_o), 1);
      tick();
      chk("next_px_x", int'(bus.x_index), 1);
      chk("next_px_he", int'(bus.hs_edge_o), 0);
      tick();

      // Column counter saturation
      drive(0, 0, 0, 0, 1, 0); tick();
      idle(); tick();
      for (int i = 0; i < X_SAT + 50; i++) begin
         drive(9, 9, 9, 1, 0, 0); tick();
      end
      drive(0, 0, 0, 0, 1, 0); tick();
      chk("line_len_sat", int'(bus.line_len), X_SAT);
      idle(); tick();

      // Row counter saturation: one pixel per line
      drive(0, 0, 0, 0, 0, 1); tick();
      idle(); tick();
      for (int i = 0; i < Y_SAT + 6; i++) begin
         drive(0, 0, 0, 1, 1, 0); tick();
         idle(); tick();
      end
      tick();
      chk("row_sat_dv", int'(bus.dv_o), 1);
      chk("row_sat", int'(bus.y_index), Y_SAT);

      // Random video
      drive(0, 0, 0, 0, 0, 1); tick();
      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
               ($urandom_range(0, 3) != 0) ? 1 : 0,
               ($urandom_range(0, 9) == 0) ? int'(~bus.hs_i) : int'(bus.hs_i),
               ($urandom_range(0, 59) == 0) ? int'(~bus.vs_i) : int'(bus.vs_i));
         tick();
      end

      // Mid-line asynchronous reset with hsync held high
      drive(0, 0, 0, 0, 0, 0); tick();
      drive(90, 90, 90, 1, 1, 0);
      repeat (5) tick();
      #2;
      rst = 1'b1;
      #1;
      outs = int'(bus.y_o) + int'(bus.dv_o) + int'(bus.hs_o) + int'(bus.vs_o) +
             int'(bus.hs_edge_o) + int'(bus.x_index) + int'(bus.y_index) + int'(bus.line_len);
      chk("async_reset_outputs", outs, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      model_reset();
      rst = 1'b0;
      tick();
      chk("post_reset_dv1", int'(bus.dv_o), 0);
      tick();
      chk("post_reset_dv2", int'(bus.dv_o), 0);
      tick();
      chk("post_reset_dv3", int'(bus.dv_o), 1);
      chk("post_reset_he", int'(bus.hs_edge_o), 1);
      chk("post_reset_x", int'(bus.x_index), 0);
      tick();
      chk("post_reset_x_next", int'(bus.x_index), 1);
      idle();
      repeat (4) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
